line_mem_ctrl: RTL and testbench

- Line-granular backing memory controller that sits directly downstream of the 4-way cache.
- Consumes the cache's mem_req_* pulses: 256-bit writebacks and line fetches addressed by 15-bit block number.
- Returns fetched lines on mem_resp_valid/mem_resp_rdata with fixed, parameterised latency.
- Serialises operations in order through a small request queue, because the cache issues requests without a ready handshake (dirty writeback immediately followed by a fetch).

---
 rtl/line_mem_pkg.sv | 33 +++
 rtl/line_mem_ctrl_if.sv | 25 ++
 rtl/line_mem_req_fifo.sv | 65 ++++++
 rtl/line_mem_ctrl.sv | 119 +++++++++++
 tb/tb_line_mem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_mem_pkg.sv
// Shared types and constants for the line-granular backing memory controller.
package line_mem_pkg;

   localparam int ADDR_BITS      = 15;
   localparam int LINE_BITS      = 256;
   localparam int WORDS_PER_LINE = 8;
   localparam int WORD_BITS      = LINE_BITS / WORDS_PER_LINE;

   // One queued memory operation: rw=1 writes wdata to addr, rw=0 reads addr.
   typedef struct packed {
      logic                 rw;
      logic [ADDR_BITS-1:0] addr;
      logic [LINE_BITS-1:0] wdata;
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_e;

   // Contents of a line that has never been written: word w of line a is
   // {5'b0, a, 9'b0, w[2:0]}.
   function automatic logic [LINE_BITS-1:0] init_line(input logic [ADDR_BITS-1:0] a);
      logic [LINE_BITS-1:0] l;
      l = '0;
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
         l[w*WORD_BITS +: WORD_BITS] = {5'b0, a, 9'b0, 3'(w)};
      end
      return l;
   endfunction

endpackage

// File: rtl/line_mem_ctrl_if.sv
// Cache-side request/response bus. Requests are one-cycle pulses with no
// ready: mem_req_valid high at a rising edge is a request, and the memory must
// either queue it or flag overflow. mem_resp_valid is a one-cycle pulse that
// qualifies mem_resp_rdata; there is no back-pressure on responses either.
interface line_mem_ctrl_if;
   import line_mem_pkg::*;

   logic                 mem_req_valid;
   logic                 mem_req_rw;
   logic [ADDR_BITS-1:0] mem_req_addr;
   logic [LINE_BITS-1:0] mem_req_wdata;
   logic                 mem_resp_valid;
   logic [LINE_BITS-1:0] mem_resp_rdata;

   modport master (
      output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
      input  mem_resp_valid, mem_resp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
      output mem_resp_valid, mem_resp_rdata
   );

endinterface

// File: rtl/line_mem_req_fifo.sv
// Small synchronous request queue of mem_op_t. A pop on an empty queue is
// ignored, so a same-edge push lands and stays. A push on a full queue is
// accepted only if a pop frees the slot on the same edge.
module line_mem_req_fifo
   import line_mem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push_i,
   input  logic    pop_i,
   input  mem_op_t din_i,
   output mem_op_t dout_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int              PW      = $clog2(DEPTH);
   localparam logic [PW-1:0]   PTR_ONE = PW'(1);
   localparam logic [PW:0]     CNT_ONE = (PW+1)'(1);
   localparam logic [PW:0]     CNT_MAX = (PW+1)'(DEPTH);

   mem_op_t       entries_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CNT_MAX);
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = entries_q[rd_ptr_q];

   // Next pointer and occupancy values from the accepted push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
   end

   // Pointer and occupancy registers; reset empties the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care while not occupied.
   always_ff @(posedge clk) begin
      if (do_push) entries_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/line_mem_ctrl.sv
// Line-granular backing memory behind the cache. Requests are queued and
// serviced strictly in order; each occupies the engine for LATENCY+1 cycles
// (pop edge through the DONE cycle) and reads answer with a one-cycle pulse.
module line_mem_ctrl
   import line_mem_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int QDEPTH  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   line_mem_ctrl_if.slave bus,
   output logic           busy,
   output logic           overflow,
   output logic [15:0]    rd_count,
   output logic [15:0]    wr_count,
   output mem_state_e     dbg_state_o
);

   localparam int         LINE_DEPTH = 2 ** ADDR_BITS;
   localparam logic [7:0] CNT_LOAD   = 8'(LATENCY - 1);

   mem_state_e           state_q, state_d;
   logic [7:0]           cnt_q, cnt_d;
   mem_op_t              op_q, op_d;
   mem_op_t              fifo_din, fifo_head;
   logic                 fifo_pop, fifo_full, fifo_empty;
   logic                 done_rd, done_wr;
   logic [LINE_BITS-1:0] line_rd, rdata_q;
   logic [15:0]          rd_count_q, wr_count_q;
   logic                 overflow_q;

   // Line storage plus a map of lines written since power-up; unwritten lines
   // read back as the init pattern. Neither is touched by reset.
   logic [LINE_BITS-1:0]  mem_q [LINE_DEPTH];
   logic [LINE_DEPTH-1:0] written_q;

   assign fifo_din = '{rw: bus.mem_req_rw, addr: bus.mem_req_addr, wdata: bus.mem_req_wdata};

   line_mem_req_fifo #(.DEPTH(QDEPTH)) u_req_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (bus.mem_req_valid),
      .pop_i   (fifo_pop),
      .din_i   (fifo_din),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign done_rd = (state_q == DONE) && !op_q.rw;
   assign done_wr = (state_q == DONE) &&  op_q.rw;
   assign line_rd = written_q[op_q.addr] ? mem_q[op_q.addr] : init_line(op_q.addr);

   // Service engine: load an op, count out its latency, complete it, and
   // chain straight into the next queued op from DONE without passing IDLE.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               op_d     = fifo_head;
               cnt_d    = CNT_LOAD;
               state_d  = BUSY;
            end else begin
               state_d  = IDLE;
            end
         end
         BUSY: begin
            if (cnt_q == '0) state_d = DONE;
            else             cnt_d   = cnt_q - 8'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Engine state, op register, held read data, counters and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         rdata_q    <= '0;
         rd_count_q <= '0;
         wr_count_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         if (done_rd) rdata_q <= line_rd;
         if (done_rd && rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
         if (done_wr && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
         if (bus.mem_req_valid && fifo_full && !fifo_pop) overflow_q <= 1'b1;
      end
   end

   // Write commit at the end of the DONE cycle; a reset before that edge
   // forces the engine to IDLE and the write is lost.
   always_ff @(posedge clk) begin
      if (done_wr) begin
         mem_q[op_q.addr]     <= op_q.wdata;
         written_q[op_q.addr] <= 1'b1;
      end
   end

   assign bus.mem_resp_valid = done_rd;
   assign bus.mem_resp_rdata = done_rd ? line_rd : rdata_q;
   assign busy               = !fifo_empty || (state_q != IDLE);
   assign overflow           = overflow_q;
   assign rd_count           = rd_count_q;
   assign wr_count           = wr_count_q;
   assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Bench for line_mem_ctrl: reset, isolated read, writeback+fetch, full queue
// with same-edge pop, overflow, reset mid-op and a random op stream.
module tb_line_mem_ctrl;
  import line_mem_pkg::*;

  localparam int LAT = 4;
  localparam int QD  = 4;
  localparam int TMO = 400;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, overflow;
  logic [15:0] rd_count, wr_count;
  mem_state_e dbg_state;

  line_mem_ctrl_if bus();

  line_mem_ctrl #(.LATENCY(LAT), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .overflow(overflow),
    .rd_count(rd_count), .wr_count(wr_count), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int n_resp = 0;

  // ---------------- reference model ----------------
  // Timing model: an op accepted at edge t is popped at max(t+1, previous
  // op's finishing edge); its DONE cycle follows edge pop+LAT and it finishes
  // at edge pop+LAT+1. Queue occupancy at edge t = accepted ops not yet popped.
  logic [LINE_BITS-1:0] mdl_mem [int];
  int                   pend_pop[$];
  int                   prev_done = 0;
  logic [LINE_BITS-1:0] exp_q[$];
  int                   exp_cyc_q[$];
  int                   exp_rd = 0;
  int                   exp_wr = 0;
  logic                 exp_ovf = 1'b0;

  function automatic logic [LINE_BITS-1:0] model_line(input int a);
    logic [LINE_BITS-1:0] l;
    if (mdl_mem.exists(a)) return mdl_mem[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (a << 12) | w;
    return l;
  endfunction

  function automatic void model_push(input int t, input bit rw, input int a, input logic [LINE_BITS-1:0] d);
    int pop;
    while (pend_pop.size() > 0 && pend_pop[0] <= t) void'(pend_pop.pop_front());
    if (pend_pop.size() < QD) begin
      pop = (t + 1 > prev_done) ? t + 1 : prev_done;
      prev_done = pop + LAT + 1;
      pend_pop.push_back(pop);
      if (rw) begin
        mdl_mem[a] = d;
        exp_wr++;
      end else begin
        exp_q.push_back(model_line(a));
        exp_cyc_q.push_back(pop + LAT);
        exp_rd++;
      end
    end else begin
      exp_ovf = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    pend_pop.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    prev_done = 0;
    exp_rd = 0;
    exp_wr = 0;
    exp_ovf = 1'b0;
  endfunction

  function automatic logic [LINE_BITS-1:0] rand_line();
    logic [LINE_BITS-1:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus.mem_resp_valid) begin
      int ec;
      logic [LINE_BITS-1:0] ed;
      n_resp++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL resp_unexpected: pulse at cycle %0d rdata=%h, required no pulse", cyc, bus.mem_resp_rdata);
      end else begin
        ec = exp_cyc_q.pop_front();
        ed = exp_q.pop_front();
        if (ec != cyc || ed !== bus.mem_resp_rdata) begin
          n_err++;
          $display("FAIL resp_data: cycle %0d rdata=%h, required cycle %0d rdata=%h", cyc, bus.mem_resp_rdata, ec, ed);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic put_op(input bit rw, input int a, input logic [LINE_BITS-1:0] d);
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = rw;
    bus.mem_req_addr  = ADDR_BITS'(a);
    bus.mem_req_wdata = d;
    model_push(cyc + 1, rw, a, d);
  endtask

  task automatic drive_op(input bit rw, input int a, input logic [LINE_BITS-1:0] d);
    @(negedge clk);
    put_op(rw, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.mem_req_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(negedge clk);
    bus.mem_req_valid = 1'b0;
    while ((cyc < prev_done || exp_q.size() != 0) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= TMO) begin
      n_err++;
      $display("FAIL %s_drain: %0d responses outstanding after %0d cycles, required 0", name, exp_q.size(), n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    idle(3);
    n_cmp += 7;
    if (bus.mem_resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b, required 0", bus.mem_resp_valid); end
    if (bus.mem_resp_rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h, required 0", bus.mem_resp_rdata); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
    if (rd_count !== 16'd0) begin n_err++; $display("FAIL reset_rd_count: got %0d, required 0", rd_count); end
    if (wr_count !== 16'd0) begin n_err++; $display("FAIL reset_wr_count: got %0d, required 0", wr_count); end
    if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_isolated_read();
    int r0 = n_resp;
    drive_op(1'b0, 'h0012, '0);
    drain("iso");
    n_cmp += 5;
    if (n_resp - r0 != 1) begin n_err++; $display("FAIL iso_pulses: got %0d, required 1", n_resp - r0); end
    if (bus.mem_resp_rdata[3*32 +: 32] !== 32'h00012003) begin n_err++; $display("FAIL iso_word3: got %h, required 00012003", bus.mem_resp_rdata[3*32 +: 32]); end
    if (bus.mem_resp_rdata[0 +: 32] !== 32'h00012000) begin n_err++; $display("FAIL iso_word0: got %h, required 00012000", bus.mem_resp_rdata[0 +: 32]); end
    if (rd_count !== 16'd1) begin n_err++; $display("FAIL iso_rd_count: got %0d, required 1", rd_count); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL iso_busy: got %b, required 0", busy); end
  endtask

  task automatic test_wb_then_fetch();
    int r0 = n_resp;
    logic [LINE_BITS-1:0] wl = {8{32'hDEADBEEF}};
    drive_op(1'b1, 'h7A03, wl);
    drive_op(1'b0, 'h7A03, '0);
    drain("wbf");
    n_cmp += 4;
    if (n_resp - r0 != 1) begin n_err++; $display("FAIL wbf_pulses: got %0d, required 1", n_resp - r0); end
    if (bus.mem_resp_rdata !== wl) begin n_err++; $display("FAIL wbf_rdata: got %h, required %h", bus.mem_resp_rdata, wl); end
    if (wr_count !== 16'(exp_wr)) begin n_err++; $display("FAIL wbf_wr_count: got %0d, required %0d", wr_count, exp_wr); end
    if (rd_count !== 16'(exp_rd)) begin n_err++; $display("FAIL wbf_rd_count: got %0d, required %0d", rd_count, exp_rd); end
  endtask

  task automatic test_full_pop();
    int r0 = n_resp;
    int t0 = cyc + 2;           // edge sampling the first request below
    int tgt = t0 + LAT + 2;     // edge where op 1 is popped off a full queue
    for (int i = 0; i < 5; i++) drive_op(1'b0, 'h20 + i, '0);
    do begin
      @(negedge clk);
      bus.mem_req_valid = 1'b0;
    end while (cyc + 1 < tgt);
    put_op(1'b0, 'h7A03, '0);
    drain("fullpop");
    n_cmp += 3;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_overflow: got %b, required 0", overflow); end
    if (n_resp - r0 != 6) begin n_err++; $display("FAIL fullpop_pulses: got %0d, required 6", n_resp - r0); end
    if (bus.mem_resp_rdata !== {8{32'hDEADBEEF}}) begin n_err++; $display("FAIL fullpop_last_rdata: got %h, required all DEADBEEF", bus.mem_resp_rdata); end
  endtask

  task automatic test_overflow();
    int r0 = n_resp;
    for (int i = 0; i < 6; i++) drive_op(1'b0, i, '0);
    drain("ovf");
    n_cmp += 4;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b, required 1", overflow); end
    if (n_resp - r0 != 5) begin n_err++; $display("FAIL ovf_pulses: got %0d, required 5", n_resp - r0); end
    if (bus.mem_resp_rdata[0 +: 32] !== 32'h00004000) begin n_err++; $display("FAIL ovf_last_word0: got %h, required 00004000", bus.mem_resp_rdata[0 +: 32]); end
    if (rd_count !== 16'(exp_rd)) begin n_err++; $display("FAIL ovf_rd_count: got %0d, required %0d", rd_count, exp_rd); end
  endtask

  task automatic test_reset_mid_op();
    // This write is interrupted, so it is kept out of the model on purpose.
    @(negedge clk);
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = 1'b1;
    bus.mem_req_addr  = ADDR_BITS'('h0100);
    bus.mem_req_wdata = '1;
    idle(2);
    rst_n = 1'b0;
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    n_cmp += 4;
    if (rd_count !== 16'd0) begin n_err++; $display("FAIL rstmid_rd_count: got %0d, required 0", rd_count); end
    if (wr_count !== 16'd0) begin n_err++; $display("FAIL rstmid_wr_count: got %0d, required 0", wr_count); end
    if (overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow: got %b, required 0", overflow); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    drive_op(1'b0, 'h0100, '0);
    drain("rstmid");
    n_cmp += 3;
    if (bus.mem_resp_rdata[0 +: 32] !== 32'h00100000) begin n_err++; $display("FAIL rstmid_word0: got %h, required 00100000", bus.mem_resp_rdata[0 +: 32]); end
    if (bus.mem_resp_rdata[7*32 +: 32] !== 32'h00100007) begin n_err++; $display("FAIL rstmid_word7: got %h, required 00100007", bus.mem_resp_rdata[7*32 +: 32]); end
    if (rd_count !== 16'd1) begin n_err++; $display("FAIL rstmid_rd_after: got %0d, required 1", rd_count); end
  endtask

  task automatic test_random();
    int r0 = n_resp;
    int e0 = exp_rd;
    for (int i = 0; i < 60; i++) begin
      drive_op(1'($urandom_range(0, 1)), $urandom_range(0, 63), rand_line());
      idle($urandom_range(0, 4));
    end
    drain("rand");
    n_cmp += 5;
    if (n_resp - r0 != exp_rd - e0) begin n_err++; $display("FAIL rand_pulses: got %0d, required %0d", n_resp - r0, exp_rd - e0); end
    if (rd_count !== 16'(exp_rd)) begin n_err++; $display("FAIL rand_rd_count: got %0d, required %0d", rd_count, exp_rd); end
    if (wr_count !== 16'(exp_wr)) begin n_err++; $display("FAIL rand_wr_count: got %0d, required %0d", wr_count, exp_wr); end
    if (overflow !== exp_ovf) begin n_err++; $display("FAIL rand_overflow: got %b, required %b", overflow, exp_ovf); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rand_busy: got %b, required 0", busy); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.mem_req_valid = 1'b0;
    bus.mem_req_rw    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    test_reset();
    test_isolated_read();
    test_wb_then_fetch();
    test_full_pop();
    test_overflow();
    test_reset_mid_op();
    test_random();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
